mem_port_arbiter: RTL and testbench

// - Shares one single-port memory between the CPU fetch requester (IF) and the load/store requester (D).
// - Sits between the multi-cycle cpu and the unified memory model.
// - One transaction outstanding at a time; round-robin arbitration; watchdog on unresponsive memory.
// - Returns responses to the owning requester.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between
// the instruction fetch port and the load/store port.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_valid_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_req_ready_o,
    output logic                  if_resp_valid_o,
    output logic [DATA_WIDTH-1:0] if_resp_data_o,
    output logic                  if_resp_err_o,
    input  logic                  d_req_valid_i,
    input  logic                  d_req_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_req_ready_o,
    output logic                  d_resp_valid_o,
    output logic [DATA_WIDTH-1:0] d_resp_data_o,
    output logic                  d_resp_err_o,
    output logic                  mem_req_valid_o,
    output logic                  mem_req_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic          owner_d;
    logic          last_d;
    logic [CW-1:0] cnt;
    logic          grant_if;
    logic          grant_d;

    // Pick a requester in IDLE; on contention favour the one not served last.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE && !rst_i) begin
            if (if_req_valid_i && d_req_valid_i) begin
                if (last_d) begin
                    grant_if = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (if_req_valid_i) begin
                grant_if = 1'b1;
            end else if (d_req_valid_i) begin
                grant_d = 1'b1;
            end
        end
    end

    assign if_req_ready_o = grant_if;
    assign d_req_ready_o  = grant_d;

    // Transaction FSM; mem_req_we_o doubles as the latched write flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            owner_d         <= 1'b0;
            last_d          <= 1'b1;
            cnt             <= '0;
            if_resp_valid_o <= 1'b0;
            if_resp_data_o  <= '0;
            if_resp_err_o   <= 1'b0;
            d_resp_valid_o  <= 1'b0;
            d_resp_data_o   <= '0;
            d_resp_err_o    <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req_we_o    <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
        end else begin
            if_resp_valid_o <= 1'b0;
            d_resp_valid_o  <= 1'b0;
            mem_req_valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_if) begin
                        owner_d         <= 1'b0;
                        last_d          <= 1'b0;
                        mem_addr_o      <= if_addr_i;
                        mem_req_we_o    <= 1'b0;
                        mem_wdata_o     <= '0;
                        mem_req_valid_o <= 1'b1;
                        state           <= ISSUE;
                    end else if (grant_d) begin
                        owner_d         <= 1'b1;
                        last_d          <= 1'b1;
                        mem_addr_o      <= d_addr_i;
                        mem_req_we_o    <= d_req_we_i;
                        mem_wdata_o     <= d_wdata_i;
                        mem_req_valid_o <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_resp_valid_i) begin
                        if (owner_d) begin
                            d_resp_valid_o <= 1'b1;
                            d_resp_err_o   <= 1'b0;
                            d_resp_data_o  <= mem_req_we_o ? '0 : mem_resp_data_i;
                        end else begin
                            if_resp_valid_o <= 1'b1;
                            if_resp_err_o   <= 1'b0;
                            if_resp_data_o  <= mem_resp_data_i;
                        end
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        if (owner_d) begin
                            d_resp_valid_o <= 1'b1;
                            d_resp_err_o   <= 1'b1;
                            d_resp_data_o  <= '0;
                        end else begin
                            if_resp_valid_o <= 1'b1;
                            if_resp_err_o   <= 1'b1;
                            if_resp_data_o  <= '0;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency
// memory model (L=3, mem[i]=i*100).
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          if_req_valid_i;
    logic [AW-1:0] if_addr_i;
    logic          if_req_ready_o;
    logic          if_resp_valid_o;
    logic [DW-1:0] if_resp_data_o;
    logic          if_resp_err_o;
    logic          d_req_valid_i;
    logic          d_req_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_req_ready_o;
    logic          d_resp_valid_o;
    logic [DW-1:0] d_resp_data_o;
    logic          d_resp_err_o;
    logic          mem_req_valid_o;
    logic          mem_req_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_resp_valid_i;
    logic [DW-1:0] mem_resp_data_i;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .if_req_valid_i(if_req_valid_i),
        .if_addr_i(if_addr_i),
        .if_req_ready_o(if_req_ready_o),
        .if_resp_valid_o(if_resp_valid_o),
        .if_resp_data_o(if_resp_data_o),
        .if_resp_err_o(if_resp_err_o),
        .d_req_valid_i(d_req_valid_i),
        .d_req_we_i(d_req_we_i),
        .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i),
        .d_req_ready_o(d_req_ready_o),
        .d_resp_valid_o(d_resp_valid_o),
        .d_resp_data_o(d_resp_data_o),
        .d_resp_err_o(d_resp_err_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_we_o(mem_req_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i(mem_resp_data_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
        int          at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Memory model: answers LAT cycles after a request, or stays silent.
    logic [31:0] mem [0:255];
    bit          mem_init = 1'b0;
    int          pend = 0;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_we;
    bit          silent = 1'b0;
    int          inj_req = 0;
    int          inj_seen = 0;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = i * 100;
            mem_init = 1'b1;
        end
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_resp_valid_i = 1'b1;
                if (p_we) begin
                    mem[p_addr[7:0]] = p_wdata;
                    mem_resp_data_i  = 32'hDEAD;
                end else begin
                    mem_resp_data_i = mem[p_addr[7:0]];
                end
            end
        end
        if (inj_req != inj_seen) begin
            inj_seen         = inj_req;
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = 32'h1234_5678;
        end
        if (mem_req_valid_o && !silent) begin
            pend    = LAT;
            p_addr  = mem_addr_o;
            p_we    = mem_req_we_o;
            p_wdata = mem_wdata_o;
        end
    end

    // Response monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (if_resp_valid_o || d_resp_valid_o) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got if=%0d d=%0d expected none",
                         if_resp_valid_o, d_resp_valid_o);
            end else begin
                e = sbq.pop_front();
                chk("resp_d_valid", d_resp_valid_o, e.is_d);
                chk("resp_if_valid", if_resp_valid_o, !e.is_d);
                chk("resp_data", e.is_d ? d_resp_data_o : if_resp_data_o,
                    e.data);
                chk("resp_err", e.is_d ? d_resp_err_o : if_resp_err_o, e.err);
                chk("resp_cycle", cyc, e.at);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    task automatic do_if(input logic [31:0] a, input logic [31:0] exp,
                         input bit want_resp);
        int n = 0;
        tick();
        if_req_valid_i = 1'b1;
        if_addr_i      = a;
        @(negedge clk);
        while (!if_req_ready_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("if_grant", if_req_ready_o, 1);
        chk("if_grant_d_ready", d_req_ready_o, 0);
        if (want_resp)
            sbq.push_back('{is_d: 1'b0, data: exp, err: 1'b0,
                            at: cyc + LAT + 2});
        tick();
        if_req_valid_i = 1'b0;
        @(negedge clk);
        chk("if_issue_valid", mem_req_valid_o, 1);
        chk("if_issue_addr", mem_addr_o, a);
        chk("if_issue_we", mem_req_we_o, 0);
    endtask

    task automatic do_d(input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp,
                        input bit err, input int lat);
        int n = 0;
        tick();
        d_req_valid_i = 1'b1;
        d_req_we_i    = we;
        d_addr_i      = a;
        d_wdata_i     = wd;
        @(negedge clk);
        while (!d_req_ready_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("d_grant", d_req_ready_o, 1);
        sbq.push_back('{is_d: 1'b1, data: exp, err: err, at: cyc + lat});
        tick();
        d_req_valid_i = 1'b0;
        @(negedge clk);
        chk("d_issue_valid", mem_req_valid_o, 1);
        chk("d_issue_addr", mem_addr_o, a);
        chk("d_issue_we", mem_req_we_o, we);
        if (we) chk("d_issue_wdata", mem_wdata_o, wd);
    endtask

    task automatic run_both(input logic [31:0] ia, input logic [31:0] iexp,
                            input logic [31:0] da, input logic [31:0] dexp);
        int n = 0;
        int t0;
        tick();
        if_req_valid_i = 1'b1;
        if_addr_i      = ia;
        d_req_valid_i  = 1'b1;
        d_req_we_i     = 1'b0;
        d_addr_i       = da;
        d_wdata_i      = '0;
        @(negedge clk);
        while (!(if_req_ready_o || d_req_ready_o) && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("both_first_if", if_req_ready_o, 1);
        chk("both_first_not_d", d_req_ready_o, 0);
        t0 = cyc;
        sbq.push_back('{is_d: 1'b0, data: iexp, err: 1'b0,
                        at: cyc + LAT + 2});
        tick();
        if_req_valid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!d_req_ready_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("both_second_d", d_req_ready_o, 1);
        chk("both_gap", cyc - t0, LAT + 2);
        sbq.push_back('{is_d: 1'b1, data: dexp, err: 1'b0,
                        at: cyc + LAT + 2});
        tick();
        d_req_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int prev;
        rst_i          = 1'b1;
        if_req_valid_i = 1'b1;
        if_addr_i      = 32'd1;
        d_req_valid_i  = 1'b1;
        d_req_we_i     = 1'b0;
        d_addr_i       = 32'd2;
        d_wdata_i      = '0;
        @(negedge clk);
        chk("rst_if_ready", if_req_ready_o, 0);
        chk("rst_d_ready", d_req_ready_o, 0);
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_if_resp", if_resp_valid_o, 0);
        chk("rst_d_resp", d_resp_valid_o, 0);
        tick();
        if_req_valid_i = 1'b0;
        d_req_valid_i  = 1'b0;
        rst_i          = 1'b0;

        do_if(32'd5, 32'd500, 1'b1);
        drain();

        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        run_both(32'd3, 32'd300, 32'd7, 32'd700);
        drain();
        run_both(32'd4, 32'd400, 32'd8, 32'd800);
        drain();

        do_d(1'b1, 32'd13, 32'd1, 32'd0, 1'b0, LAT + 2);
        drain();
        do_d(1'b0, 32'd13, 32'd0, 32'd1, 1'b0, LAT + 2);
        drain();

        silent = 1'b1;
        do_d(1'b0, 32'd20, 32'd0, 32'd0, 1'b1, TO + 2);
        drain();
        silent = 1'b0;
        tick();
        tick();
        inj_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_no_if", if_resp_valid_o, 0);
            chk("late_no_d", d_resp_valid_o, 0);
        end

        do_if(32'd9, 32'd0, 1'b0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("mrst_mem_valid", mem_req_valid_o, 0);
        chk("mrst_mem_we", mem_req_we_o, 0);
        chk("mrst_mem_addr", mem_addr_o, 0);
        chk("mrst_mem_wdata", mem_wdata_o, 0);
        chk("mrst_if_valid", if_resp_valid_o, 0);
        chk("mrst_if_data", if_resp_data_o, 0);
        chk("mrst_if_err", if_resp_err_o, 0);
        chk("mrst_d_valid", d_resp_valid_o, 0);
        chk("mrst_d_data", d_resp_data_o, 0);
        chk("mrst_d_err", d_resp_err_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_no_if", if_resp_valid_o, 0);
        end
        do_if(32'd6, 32'd600, 1'b1);
        drain();

        tick();
        if_req_valid_i = 1'b1;
        if_addr_i      = 32'd2;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!if_req_ready_o && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk("stream_grant", if_req_ready_o, 1);
            if (k > 0) begin
                chk("stream_gap", cyc - prev, LAT + 2);
                chk("stream_resp_at_grant", if_resp_valid_o, 1);
            end
            prev = cyc;
            sbq.push_back('{is_d: 1'b0, data: 32'd200, err: 1'b0,
                            at: cyc + LAT + 2});
        end
        tick();
        if_req_valid_i = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
